// File: rtl/wb_prefetch_buffer.sv
// rtl/wb_prefetch_buffer.sv - Wishbone line-prefetch read buffer in front of a slow BRAM slave
// Optional hit/miss statistics counters are built when PREFETCH_STATS_EN is defined.
module wb_prefetch_buffer #(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h3800_0000,
  parameter logic [31:0] WIN_BYTES = 32'h0040_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);
  localparam int IW = $clog2(DEPTH);
  localparam int LB = IW + 2;

  typedef enum logic [1:0] {IDLE, HIT, FILL, PASS} state_t;
  state_t state;

  logic [31:0]      cap_adr, cap_dat;
  logic             cap_we;
  logic [3:0]       cap_sel;
  logic [31:0]      tag;
  logic [DEPTH-1:0] valid;
  logic [31:0]      line_buf [DEPTH];
  logic [IW-1:0]    beat;
  logic             up_live;

  logic          req, req_in_win, req_hit, cap_in_win, cap_hit;
  logic [IW-1:0] req_idx, cap_idx, beat_nxt;
  logic [31:0]   req_line, cap_line, next_beat_adr;

  // A request still showing stb while its ack is on the bus is the one just served.
  assign req        = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign req_idx    = wbs_adr_i[LB-1:2];
  assign req_line   = {wbs_adr_i[31:LB], {LB{1'b0}}};
  assign req_in_win = (wbs_adr_i - BASE_ADDR) < WIN_BYTES;
  assign req_hit    = req_in_win && (tag == req_line) && valid[req_idx];

  assign cap_idx    = cap_adr[LB-1:2];
  assign cap_line   = {cap_adr[31:LB], {LB{1'b0}}};
  assign cap_in_win = (cap_adr - BASE_ADDR) < WIN_BYTES;
  assign cap_hit    = cap_in_win && (tag == cap_line) && valid[cap_idx];

  assign beat_nxt      = beat + IW'(1);
  assign next_beat_adr = tag + {{(30-IW){1'b0}}, beat_nxt, 2'b00};

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      valid     <= '0;
      tag       <= '0;
      beat      <= '0;
      up_live   <= 1'b0;
      cap_adr   <= '0;
      cap_dat   <= '0;
      cap_we    <= 1'b0;
      cap_sel   <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
    end else begin
      wbs_ack_o <= 1'b0;
      case (state)
        IDLE: if (req) begin
          cap_adr <= wbs_adr_i;
          cap_dat <= wbs_dat_i;
          cap_we  <= wbs_we_i;
          cap_sel <= wbs_sel_i;
          up_live <= 1'b1;
          if (wbs_we_i || !req_in_win) begin
            state     <= PASS;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= wbs_we_i;
            wbm_sel_o <= wbs_sel_i;
            wbm_adr_o <= wbs_adr_i;
            wbm_dat_o <= wbs_dat_i;
          end else if (req_hit) begin
            state <= HIT;
          end else begin
            state     <= FILL;
            tag       <= req_line;
            valid     <= '0;
            beat      <= '0;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'hF;
            wbm_adr_o <= req_line;
          end
        end
        HIT: begin
          wbs_ack_o <= 1'b1;
          wbs_dat_o <= line_buf[cap_idx];
          state     <= IDLE;
        end
        FILL: begin
          if (!wbs_cyc_i) up_live <= 1'b0;
          if (wbm_stb_o && wbm_ack_i) begin
            wbm_stb_o   <= 1'b0;
            valid[beat] <= 1'b1;
            // Early restart: the requested word goes upstream as soon as it lands.
            if (beat == cap_idx) begin
              up_live <= 1'b0;
              if (up_live && wbs_cyc_i) begin
                wbs_ack_o <= 1'b1;
                wbs_dat_o <= wbm_dat_i;
              end
            end
            if (beat == IW'(DEPTH-1)) begin
              wbm_cyc_o <= 1'b0;
              state     <= IDLE;
            end else begin
              beat      <= beat_nxt;
              wbm_adr_o <= next_beat_adr;
            end
          end else if (!wbm_stb_o) begin
            wbm_stb_o <= 1'b1;
          end
        end
        PASS: begin
          if (!wbs_cyc_i) up_live <= 1'b0;
          if (wbm_stb_o && wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            state     <= IDLE;
            if (up_live && wbs_cyc_i) begin
              wbs_ack_o <= 1'b1;
              if (!cap_we) wbs_dat_o <= wbm_dat_i;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line storage; write-through merges land with the downstream write ack.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i && wbm_stb_o && wbm_ack_i) begin
      if (state == FILL) begin
        line_buf[beat] <= wbm_dat_i;
      end else if (state == PASS && cap_we && cap_hit) begin
        for (int b = 0; b < 4; b++)
          if (cap_sel[b]) line_buf[cap_idx][8*b +: 8] <= cap_dat[8*b +: 8];
      end
    end
  end

`ifdef PREFETCH_STATS_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (state == HIT && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
      if (state == IDLE && req && !wbs_we_i && req_in_win && !req_hit && miss_cnt != 16'hFFFF)
        miss_cnt <= miss_cnt + 16'd1;
    end
  end
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule
